// File: rtl/fwd_hazard_unit_p_if.sv
// fwd_hazard_unit_p_if: ID/EX/MEM register-usage bus and hazard-unit responses
interface fwd_hazard_unit_p_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_valid;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_we;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_we;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall;
    logic                      stall_busy;

    modport master (
        output id_rs, id_rs_valid, ex_rd, ex_we, ex_is_load, mem_rd, mem_we,
        input  fwd_sel, stall, stall_busy
    );

    modport slave (
        input  id_rs, id_rs_valid, ex_rd, ex_we, ex_is_load, mem_rd, mem_we,
        output fwd_sel, stall, stall_busy
    );
endinterface

// File: rtl/fwd_hazard_unit_p.sv
// fwd_hazard_unit_p: registered operand forward selects and multi-cycle load-use stall
module fwd_hazard_unit_p #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1
) (
    input logic             clk,
    input logic             rst,
    fwd_hazard_unit_p_if.slave hz_io
);
    localparam int CW = LOAD_LAT > 1 ? $clog2(LOAD_LAT) : 1;

    typedef enum logic {IDLE, STALL_WAIT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;
    logic [NUM_SRC-1:0]   match_ex, match_mem;
    logic                 luse, stall;

    always_comb begin
        logic [REG_AW-1:0] rs;
        logic              live;
        match_ex  = '0;
        match_mem = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs           = hz_io.id_rs[i*REG_AW +: REG_AW];
            live         = hz_io.id_rs_valid[i] && !(ZERO_REG != 0 && rs == '0);
            match_ex[i]  = live && hz_io.ex_we && hz_io.ex_rd == rs;
            match_mem[i] = live && hz_io.mem_we && hz_io.mem_rd == rs;
        end
    end

    assign luse = hz_io.ex_is_load && |match_ex;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (state_q == IDLE) begin
            stall = luse;
            if (luse && LOAD_LAT > 1) begin
                state_d = STALL_WAIT;
                cnt_d   = CW'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
            end
        end else begin
            stall = 1'b1;
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - 1'b1;
        end
    end

    // A stalled cycle sends a bubble into EX, so nothing should be forwarded to it.
    always_comb begin
        fwd_sel_d = '0;
        for (int i = 0; i < NUM_SRC; i++)
            fwd_sel_d[2*i +: 2] = stall ? 2'b00 : match_ex[i] ? 2'b01 : match_mem[i] ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fwd_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    // Mealy stall must drop the moment reset rises, even with a hazard on the inputs.
    assign hz_io.stall      = stall && !rst;
    assign hz_io.stall_busy = state_q == STALL_WAIT;
    assign hz_io.fwd_sel    = fwd_sel_q;
endmodule

// File: tb/tb_fwd_hazard_unit_p.sv
// tb_fwd_hazard_unit_p: LOAD_LAT=1 and LOAD_LAT=3 units on shared stimulus vs a cycle-count model
module tb_fwd_hazard_unit_p;
    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NS*AW-1:0] rs;
    logic [NS-1:0]    vld;
    logic [AW-1:0]    erd, mrd;
    logic             ewe, eld, mwe;

    fwd_hazard_unit_p_if #(.REG_AW(AW), .NUM_SRC(NS)) if1 ();
    fwd_hazard_unit_p_if #(.REG_AW(AW), .NUM_SRC(NS)) if3 ();

    assign if1.id_rs = rs;  assign if1.id_rs_valid = vld; assign if1.ex_rd = erd;
    assign if1.ex_we = ewe; assign if1.ex_is_load = eld;  assign if1.mem_rd = mrd; assign if1.mem_we = mwe;
    assign if3.id_rs = rs;  assign if3.id_rs_valid = vld; assign if3.ex_rd = erd;
    assign if3.ex_we = ewe; assign if3.ex_is_load = eld;  assign if3.mem_rd = mrd; assign if3.mem_we = mwe;

    fwd_hazard_unit_p #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .hz_io(if1.slave));
    fwd_hazard_unit_p #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .ZERO_REG(1)) dut3 (
        .clk(clk), .rst(rst), .hz_io(if3.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int lat [2] = '{1, 3};
    int rem [2];
    logic [3:0] efwd [2];
    logic [3:0] h_s1, h_s3, h_b3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] fwd_of();
        logic [3:0] r = '0;
        for (int i = 0; i < NS; i++) begin
            logic [AW-1:0] a = rs[i*AW +: AW];
            bit me = vld[i] && ewe && erd == a && a != 0;
            bit mm = vld[i] && mwe && mrd == a && a != 0;
            r[2*i +: 2] = me ? 2'd1 : mm ? 2'd2 : 2'd0;
        end
        return r;
    endfunction

    function automatic bit luse_f();
        bit u = 0;
        for (int i = 0; i < NS; i++)
            if (vld[i] && ewe && erd == rs[i*AW +: AW] && rs[i*AW +: AW] != 0) u = 1;
        return eld && u;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin rem[k] = 0; efwd[k] = '0; end
    endtask

    task automatic drive(input logic [9:0] r, input logic [1:0] v, input logic [4:0] e, input logic ew,
                         input logic el, input logic [4:0] m, input logic mw);
        rs = r; vld = v; erd = e; ewe = ew; eld = el; mrd = m; mwe = mw;
    endtask

    // One pipeline cycle: inputs already driven, check at negedge, advance model at posedge.
    task automatic step();
        bit s [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) s[k] = rem[k] > 0 || luse_f();
        check("stall_l1", if1.stall, s[0]);
        check("busy_l1", if1.stall_busy, rem[0] > 0);
        check("fwd_l1", if1.fwd_sel, efwd[0]);
        check("stall_l3", if3.stall, s[1]);
        check("busy_l3", if3.stall_busy, rem[1] > 0);
        check("fwd_l3", if3.fwd_sel, efwd[1]);
        h_s1 = {h_s1[2:0], if1.stall};
        h_s3 = {h_s3[2:0], if3.stall};
        h_b3 = {h_b3[2:0], if3.stall_busy};
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            efwd[k] = s[k] ? 4'b0 : fwd_of();
            rem[k]  = rem[k] > 0 ? rem[k] - 1 : (luse_f() ? lat[k] - 1 : 0);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive({5'd5, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fwd_l1", if1.fwd_sel, 0);
        check("rst_fwd_l3", if3.fwd_sel, 0);
        check("rst_stall_l1", if1.stall, 0);
        check("rst_stall_l3", if3.stall, 0);
        check("rst_busy_l3", if3.stall_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        drive({5'd7, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1);
        step();
        check("pair_l1", if1.fwd_sel, 4'b1001);
        check("pair_l3", if3.fwd_sel, 4'b1001);

        drive({5'd0, 5'd3}, 2'b11, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1);
        step();
        check("ex_prio", if1.fwd_sel, 4'b0001);
        drive({5'd0, 5'd0}, 2'b11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        step();
        check("zero_reg", if1.fwd_sel, 4'b0000);

        // Single load-use followed by idle cycles.
        drive({5'd9, 5'd0}, 2'b10, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        check("luse_fwd_l1", if1.fwd_sel, 4'b0000);
        drive('0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) step();
        check("seq_s1", h_s1, 4'b1000);
        check("seq_s3", h_s3, 4'b1110);
        check("seq_b3", h_b3, 4'b0110);

        // Hazard held: re-stall without a gap on return to IDLE.
        drive({5'd9, 5'd0}, 2'b10, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
        repeat (4) step();
        check("b2b_s1", h_s1, 4'b1111);
        check("b2b_s3", h_s3, 4'b1111);
        check("b2b_b3", h_b3, 4'b0110);
        drive('0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) step();

        // Reset during the second stall cycle of the LOAD_LAT=3 unit.
        drive({5'd9, 5'd0}, 2'b10, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        check("pre_rst_busy", if3.stall_busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", if3.stall, 0);
        check("mid_rst_busy", if3.stall_busy, 0);
        check("mid_rst_stall_l1", if1.stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive('0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        check("post_rst_busy", if3.stall_busy, 0);

        for (int n = 0; n < 400; n++) begin
            drive({5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
